// File: rtl/marquee_pkg.sv
// Shared definitions for the marquee message path.
//   ASCII_SPACE      : blank character used for padding and idle output
//   SEG_BLANK        : all-segments-off pattern for the display driver
//   state_t          : character feeder controller states
//   DEFAULT_*        : default build parameters for the feeder
package marquee_pkg;

    localparam logic [7:0]  ASCII_SPACE = 8'h20;
    localparam logic [15:0] SEG_BLANK   = 16'hFFFF;

    localparam int DEFAULT_DEPTH    = 32;
    localparam int DEFAULT_TICK_DIV = 4194304;
    localparam int DEFAULT_PAD      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // no committed message
        ST_LOAD = 2'd1,  // host is writing characters
        ST_PLAY = 2'd2   // message is being scrolled out
    } state_t;

endpackage

// File: rtl/msg_char_feeder_if.sv
// Host-write and display-handshake signals of the character feeder.
//   wr_en/wr_char/wr_last/clear : host writes and message control
//   char_out/char_valid/char_ready : character stream to the display stage
//   msg_len/overflow            : status back to the host
// Handshake: the feeder raises char_valid with char_out and holds both
// unchanged until a cycle where char_valid and char_ready are both high;
// that cycle is the transfer. char_ready may change freely.
interface msg_char_feeder_if #(
    parameter int DEPTH = 32
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    wr_char;
    logic          wr_last;
    logic          clear;
    logic [7:0]    char_out;
    logic          char_valid;
    logic          char_ready;
    logic [LW-1:0] msg_len;
    logic          overflow;

    // master: host + display side
    modport master (
        output wr_en, wr_char, wr_last, clear, char_ready,
        input  char_out, char_valid, msg_len, overflow
    );

    // slave: the feeder itself
    modport slave (
        input  wr_en, wr_char, wr_last, clear, char_ready,
        output char_out, char_valid, msg_len, overflow
    );

endinterface

// File: rtl/scroll_tick_gen.sv
// Free-running scroll tick generator.
//   clk  : clock
//   rst  : synchronous active-high reset, restarts the count at 0
//   tick : high for one cycle when the count reaches TICK_DIV-1
module scroll_tick_gen
    import marquee_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/msg_char_feeder.sv
// Message buffer and character feeder for the scrolling marquee.
// The host loads a message character by character; once committed, one
// character (message then PAD spaces, repeating) is offered per scroll tick.
//   clk, rst  : clock and synchronous active-high reset
//   bus       : host write / display handshake / status (slave modport)
//   state_dbg : current controller state
module msg_char_feeder
    import marquee_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int TICK_DIV = DEFAULT_TICK_DIV,
    parameter int PAD      = DEFAULT_PAD
) (
    input  logic               clk,
    input  logic               rst,
    msg_char_feeder_if.slave   bus,
    output state_t             state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    state_t        state_q, state_d;
    logic [LW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] msg_len_q, msg_len_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          in_pad_q, in_pad_d;
    logic [3:0]    pad_cnt_q, pad_cnt_d;
    logic          valid_q, valid_d;
    logic [7:0]    out_q, out_d;
    logic          ovf_q, ovf_d;

    logic [7:0]    buf_mem [DEPTH];
    logic          buf_we;
    logic [AW-1:0] buf_waddr;

    logic          tick;
    logic          accept;
    logic [AW-1:0] nxt_rd;
    logic          nxt_pad;
    logic [3:0]    nxt_cnt;

    scroll_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        msg_len_d = msg_len_q;
        rd_ptr_d  = rd_ptr_q;
        in_pad_d  = in_pad_q;
        pad_cnt_d = pad_cnt_q;
        valid_d   = valid_q;
        out_d     = out_q;
        ovf_d     = ovf_q;
        buf_we    = 1'b0;
        buf_waddr = wr_ptr_q[AW-1:0];

        accept  = valid_q & bus.char_ready;
        nxt_rd  = rd_ptr_q;
        nxt_pad = in_pad_q;
        nxt_cnt = pad_cnt_q;

        // Read position after this cycle's transfer (if any). The character
        // presented on a tick always comes from this advanced position, so a
        // tick coinciding with a transfer shows the following character.
        if (accept) begin
            if (in_pad_q) begin
                if (pad_cnt_q == 4'(PAD - 1)) begin
                    nxt_pad = 1'b0;
                    nxt_cnt = '0;
                    nxt_rd  = '0;
                end else begin
                    nxt_cnt = pad_cnt_q + 4'd1;
                end
            end else if (LW'(rd_ptr_q) == msg_len_q - LW'(1)) begin
                nxt_rd  = '0;
                nxt_cnt = '0;
                nxt_pad = (PAD != 0);
            end else begin
                nxt_rd = rd_ptr_q + AW'(1);
            end
        end

        if (bus.clear) begin
            state_d   = ST_IDLE;
            msg_len_d = '0;
            wr_ptr_d  = '0;
            ovf_d     = 1'b0;
            valid_d   = 1'b0;
            out_d     = ASCII_SPACE;
            rd_ptr_d  = '0;
            in_pad_d  = 1'b0;
            pad_cnt_d = '0;
        end else if (bus.wr_en) begin
            state_d = ST_LOAD;
            valid_d = 1'b0;
            out_d   = ASCII_SPACE;
            if (state_q != ST_LOAD) begin
                // First character of a new message; old message is dropped.
                buf_we    = 1'b1;
                buf_waddr = '0;
                wr_ptr_d  = LW'(1);
                msg_len_d = '0;
            end else if (wr_ptr_q != LW'(DEPTH)) begin
                buf_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + LW'(1);
            end else begin
                ovf_d = 1'b1;
            end
            if (bus.wr_last) begin
                // wr_ptr_d saturates at DEPTH, so it is the stored count.
                state_d   = ST_PLAY;
                msg_len_d = wr_ptr_d;
                rd_ptr_d  = '0;
                in_pad_d  = 1'b0;
                pad_cnt_d = '0;
            end
        end else if (state_q == ST_PLAY) begin
            rd_ptr_d  = nxt_rd;
            in_pad_d  = nxt_pad;
            pad_cnt_d = nxt_cnt;
            if (tick && (!valid_q || accept)) begin
                valid_d = 1'b1;
                out_d   = nxt_pad ? ASCII_SPACE : buf_mem[nxt_rd];
            end else if (accept) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            msg_len_q <= '0;
            rd_ptr_q  <= '0;
            in_pad_q  <= 1'b0;
            pad_cnt_q <= '0;
            valid_q   <= 1'b0;
            out_q     <= ASCII_SPACE;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            msg_len_q <= msg_len_d;
            rd_ptr_q  <= rd_ptr_d;
            in_pad_q  <= in_pad_d;
            pad_cnt_q <= pad_cnt_d;
            valid_q   <= valid_d;
            out_q     <= out_d;
            ovf_q     <= ovf_d;
        end
    end

    // Message storage has no reset; only entries below msg_len are ever read.
    always_ff @(posedge clk) begin
        if (buf_we && !rst) begin
            buf_mem[buf_waddr] <= bus.wr_char;
        end
    end

    assign bus.char_out   = out_q;
    assign bus.char_valid = valid_q;
    assign bus.msg_len    = msg_len_q;
    assign bus.overflow   = ovf_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_msg_char_feeder.sv
module tb_msg_char_feeder;
    import marquee_pkg::*;

    localparam int DEPTH    = 8;
    localparam int TICK_DIV = 4;
    localparam int PAD      = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    msg_char_feeder_if #(.DEPTH(DEPTH)) bus ();
    state_t state_dbg;

    msg_char_feeder #(
        .DEPTH    (DEPTH),
        .TICK_DIV (TICK_DIV),
        .PAD      (PAD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The emitted stream is the message followed by PAD spaces, repeating;
    // m_k counts transferred characters since the message was committed.
    typedef enum {M_IDLE, M_LOAD, M_PLAY} mmode_t;
    mmode_t     m_mode = M_IDLE;
    logic [7:0] m_msg[$];
    int         m_k    = 0;
    int         m_tcnt = 0;
    int         m_len  = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_out   = 8'h20;
    logic       m_ovf   = 1'b0;

    function automatic logic [7:0] seq_char(input int k);
        int p;
        p = k % (m_msg.size() + PAD);
        return (p < m_msg.size()) ? m_msg[p] : 8'h20;
    endfunction

    always @(posedge clk) begin : model
        bit tick;
        bit acc;
        tick   = (m_tcnt == TICK_DIV - 1);
        m_tcnt = tick ? 0 : m_tcnt + 1;
        if (rst) begin
            m_tcnt = 0; m_mode = M_IDLE; m_valid = 1'b0; m_out = 8'h20;
            m_len = 0; m_ovf = 1'b0; m_msg.delete();
        end else if (bus.clear) begin
            m_mode = M_IDLE; m_valid = 1'b0; m_out = 8'h20;
            m_len = 0; m_ovf = 1'b0; m_msg.delete();
        end else if (bus.wr_en) begin
            m_valid = 1'b0; m_out = 8'h20;
            if (m_mode != M_LOAD) begin
                m_msg.delete(); m_msg.push_back(bus.wr_char); m_len = 0;
            end else if (m_msg.size() < DEPTH) begin
                m_msg.push_back(bus.wr_char);
            end else begin
                m_ovf = 1'b1;
            end
            m_mode = M_LOAD;
            if (bus.wr_last) begin
                m_mode = M_PLAY; m_len = m_msg.size(); m_k = 0;
            end
        end else if (m_mode == M_PLAY) begin
            acc = m_valid && bus.char_ready;
            if (acc) m_k++;
            if (tick && (!m_valid || acc)) begin
                m_valid = 1'b1;
                m_out   = seq_char(m_k);
            end else if (acc) begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- compare / collect ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("char_valid", 32'(bus.char_valid), 32'(m_valid));
            chk("char_out",   32'(bus.char_out),   32'(m_out));
            chk("msg_len",    32'(bus.msg_len),    32'(m_len));
            chk("overflow",   32'(bus.overflow),   32'(m_ovf));
            if (bus.char_valid && bus.char_ready && !rst && !bus.clear && !bus.wr_en)
                got_q.push_back(bus.char_out);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_msg(input string s);
        for (int i = 0; i < s.len(); i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_char = s[i];
            bus.wr_last = (i == s.len() - 1);
            cyc(1);
        end
        bus.wr_en   = 1'b0;
        bus.wr_last = 1'b0;
    endtask

    task automatic wait_out(input logic [7:0] c, input int budget, input string name);
        int n = 0;
        while (!(bus.char_valid && bus.char_out == c) && n < budget) begin
            cyc(1);
            n++;
        end
        chk(name, 32'(bus.char_valid && bus.char_out == c), 32'd1);
    endtask

    task automatic check_seq(input string name);
        chk({name, "_count"}, 32'(got_q.size() >= exp_q.size()), 32'd1);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                chk($sformatf("%s[%0d]", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_char = 8'h00; bus.wr_last = 1'b0;
        bus.clear = 1'b0; bus.char_ready = 1'b0;
        cyc(3);
        chk("rst_valid",   32'(bus.char_valid), 32'd0);
        chk("rst_out",     32'(bus.char_out),   32'h20);
        chk("rst_len",     32'(bus.msg_len),    32'd0);
        chk("rst_ovf",     32'(bus.overflow),   32'd0);
        chk("rst_state",   32'(state_dbg),      32'(ST_IDLE));
        rst = 1'b0;
        cmp_en = 1'b1;

        // "ABC" with the display always ready
        got_q.delete();
        write_msg("ABC");
        chk("abc_len",   32'(bus.msg_len), 32'd3);
        chk("abc_state", 32'(state_dbg),   32'(ST_PLAY));
        bus.char_ready = 1'b1;
        cyc(34);
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h20, 8'h20, 8'h41, 8'h42};
        check_seq("abc_seq");

        // single character message replacing a playing one
        bus.char_ready = 1'b0;
        got_q.delete();
        write_msg("X");
        chk("x_len", 32'(bus.msg_len), 32'd1);
        bus.char_ready = 1'b1;
        cyc(34);
        exp_q = '{8'h58, 8'h20, 8'h20, 8'h58, 8'h20, 8'h20, 8'h58};
        check_seq("x_seq");

        // nine characters into an eight entry buffer
        bus.char_ready = 1'b0;
        got_q.delete();
        write_msg("ABCDEFGHI");
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        chk("ovf_len",  32'(bus.msg_len),  32'd8);
        bus.char_ready = 1'b1;
        cyc(44);
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h20, 8'h20};
        check_seq("ovf_seq");

        // clear together with a write while playing
        bus.clear = 1'b1; bus.wr_en = 1'b1; bus.wr_char = 8'h5A; bus.wr_last = 1'b1;
        cyc(1);
        bus.clear = 1'b0; bus.wr_en = 1'b0; bus.wr_last = 1'b0;
        chk("clr_valid", 32'(bus.char_valid), 32'd0);
        chk("clr_len",   32'(bus.msg_len),    32'd0);
        chk("clr_ovf",   32'(bus.overflow),   32'd0);
        chk("clr_state", 32'(state_dbg),      32'(ST_IDLE));
        cyc(10);
        chk("clr_quiet", 32'(bus.char_valid), 32'd0);

        // display stalls across three ticks
        bus.char_ready = 1'b0;
        write_msg("ABC");
        wait_out(8'h41, 10, "stall_first");
        cyc(12);
        chk("stall_valid", 32'(bus.char_valid), 32'd1);
        chk("stall_hold",  32'(bus.char_out),   32'h41);
        got_q.delete();
        bus.char_ready = 1'b1;
        cyc(14);
        exp_q = '{8'h41, 8'h42, 8'h43};
        check_seq("stall_seq");

        // reset while 'B' is on offer
        bus.char_ready = 1'b0;
        write_msg("ABC");
        bus.char_ready = 1'b1;
        wait_out(8'h42, 20, "rst_wait_b");
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("mrst_valid", 32'(bus.char_valid), 32'd0);
        chk("mrst_out",   32'(bus.char_out),   32'h20);
        chk("mrst_len",   32'(bus.msg_len),    32'd0);
        cyc(12);
        chk("mrst_quiet", 32'(bus.char_valid), 32'd0);

        cyc(2);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
